// File: rtl/idex_forward_stage.sv
// ID/EX pipeline register with EX-stage operand/store-data forwarding muxes.
// Stall and flush requests become bubbles; stall cycles feed a saturating debug counter.
module idex_forward_stage #(
  parameter int WORD_W = 32,
  parameter int CTRL_W = 16,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              stall,
  input  logic [1:0]        forwarda_src,
  input  logic [1:0]        forwardb_src,
  input  logic [1:0]        memadd_forward,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic [WORD_W-1:0] exmem_alu,
  input  logic [WORD_W-1:0] intomem,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [WORD_W-1:0] ex_porta,
  output logic [WORD_W-1:0] ex_portb,
  output logic [WORD_W-1:0] ex_store_data,
  output logic [WORD_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_wsel,
  output logic [CNT_W-1:0]  stall_count
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [WORD_W-1:0] rdat1_reg;
  logic [WORD_W-1:0] rdat2_reg;
  logic [WORD_W-1:0] imm_reg;
  logic [REG_W-1:0]  wsel_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Select 11 is reserved and falls back to the registered operand.
  function automatic logic [WORD_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [WORD_W-1:0] held,
    input logic [WORD_W-1:0] alu,
    input logic [WORD_W-1:0] wb
  );
    case (sel)
      2'b01:   return alu;
      2'b10:   return wb;
      default: return held;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_reg     <= 1'b0;
      ctrl_reg      <= '0;
      rdat1_reg     <= '0;
      rdat2_reg     <= '0;
      imm_reg       <= '0;
      wsel_reg      <= '0;
      stall_cnt_reg <= '0;
    end else if (en) begin
      if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      // A simultaneous flush and stall still yields exactly one bubble.
      if (flush || stall) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= '0;
        rdat1_reg <= '0;
        rdat2_reg <= '0;
        imm_reg   <= '0;
        wsel_reg  <= '0;
      end else begin
        valid_reg <= id_valid;
        ctrl_reg  <= id_ctrl;
        rdat1_reg <= id_rdat1;
        rdat2_reg <= id_rdat2;
        imm_reg   <= id_imm;
        wsel_reg  <= id_wsel;
      end
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_ctrl       = ctrl_reg;
  assign ex_imm        = imm_reg;
  assign ex_wsel       = wsel_reg;
  assign stall_count   = stall_cnt_reg;
  assign ex_porta      = fwd_mux(forwarda_src,   rdat1_reg, exmem_alu, intomem);
  assign ex_portb      = fwd_mux(forwardb_src,   rdat2_reg, exmem_alu, intomem);
  assign ex_store_data = fwd_mux(memadd_forward, rdat2_reg, exmem_alu, intomem);

endmodule

// File: tb/tb_idex_forward_stage.sv
// Directed plus randomized checks of idex_forward_stage against a behavioural model.
module tb_idex_forward_stage;

  logic        CLK = 1'b0;
  logic        nRST, en, flush, stall, id_valid;
  logic [1:0]  forwarda_src, forwardb_src, memadd_forward;
  logic [15:0] id_ctrl;
  logic [31:0] id_rdat1, id_rdat2, id_imm, exmem_alu, intomem;
  logic [4:0]  id_wsel;
  logic        ex_valid;
  logic [15:0] ex_ctrl, stall_count;
  logic [31:0] ex_porta, ex_portb, ex_store_data, ex_imm;
  logic [4:0]  ex_wsel;

  int tests = 0;
  int fails = 0;

  // Behavioural model: what the EX stage should currently hold.
  logic        m_valid;
  logic [15:0] m_ctrl;
  logic [31:0] m_r1, m_r2, m_imm;
  logic [4:0]  m_wsel;
  int          m_cnt;

  idex_forward_stage dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .stall(stall),
    .forwarda_src(forwarda_src), .forwardb_src(forwardb_src), .memadd_forward(memadd_forward),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_imm(id_imm), .id_wsel(id_wsel), .exmem_alu(exmem_alu), .intomem(intomem),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_porta(ex_porta), .ex_portb(ex_portb),
    .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_wsel(ex_wsel), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] held);
    if (sel == 2'd1) return exmem_alu;
    if (sel == 2'd2) return intomem;
    return held;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, "_ctrl"},  64'(ex_ctrl),  64'(m_ctrl));
    chk({tag, "_porta"}, 64'(ex_porta), 64'(pick(forwarda_src, m_r1)));
    chk({tag, "_portb"}, 64'(ex_portb), 64'(pick(forwardb_src, m_r2)));
    chk({tag, "_store"}, 64'(ex_store_data), 64'(pick(memadd_forward, m_r2)));
    chk({tag, "_imm"},   64'(ex_imm),   64'(m_imm));
    chk({tag, "_wsel"},  64'(ex_wsel),  64'(m_wsel));
    chk({tag, "_cnt"},   64'(stall_count), 64'(m_cnt));
  endtask

  // One rising edge; model follows the reset > freeze > bubble > capture rules.
  task automatic tick();
    @(posedge CLK);
    if (!nRST) begin
      m_valid = 0; m_ctrl = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_wsel = 0; m_cnt = 0;
    end else if (en) begin
      if (stall && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (flush || stall) begin
        m_valid = 0; m_ctrl = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_wsel = 0;
      end else begin
        m_valid = id_valid; m_ctrl = id_ctrl; m_r1 = id_rdat1; m_r2 = id_rdat2;
        m_imm = id_imm; m_wsel = id_wsel;
      end
    end
    #1;
  endtask

  initial begin
    nRST = 0; en = 1; flush = 0; stall = 0; id_valid = 0;
    forwarda_src = 0; forwardb_src = 0; memadd_forward = 0;
    id_ctrl = 0; id_rdat1 = 0; id_rdat2 = 0; id_imm = 0; id_wsel = 0;
    exmem_alu = 0; intomem = 0;
    m_valid = 1'bx; m_ctrl = 'x; m_r1 = 'x; m_r2 = 'x; m_imm = 'x; m_wsel = 'x; m_cnt = 0;

    // Reset, then capture
    tick(); tick();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_cnt", 64'(stall_count), 64'd0);
    chk("rst_porta", 64'(ex_porta), 64'd0);
    nRST = 1; id_valid = 1; id_rdat1 = 32'h11; id_rdat2 = 32'h22; id_wsel = 5;
    tick();
    chk("cap_valid", 64'(ex_valid), 64'd1);
    chk("cap_porta", 64'(ex_porta), 64'h11);
    chk("cap_portb", 64'(ex_portb), 64'h22);
    chk("cap_wsel", 64'(ex_wsel), 64'd5);
    chk("cap_cnt", 64'(stall_count), 64'd0);

    // Forwarding sources, no clock edge needed
    en = 0; exmem_alu = 32'hAAAA; intomem = 32'hBBBB;
    forwarda_src = 2'b01; #1 chk("fwd_a01", 64'(ex_porta), 64'hAAAA);
    forwarda_src = 2'b10; #1 chk("fwd_a10", 64'(ex_porta), 64'hBBBB);
    forwarda_src = 2'b11; #1 chk("fwd_a11", 64'(ex_porta), 64'h11);
    memadd_forward = 2'b10; forwardb_src = 2'b00;
    #1 chk("fwd_store", 64'(ex_store_data), 64'hBBBB);
    chk("fwd_b_held", 64'(ex_portb), 64'h22);
    forwarda_src = 0; memadd_forward = 0; en = 1;

    // Load-use stall, then release
    stall = 1; id_ctrl = 16'h00F3;
    tick();
    chk("stall_valid", 64'(ex_valid), 64'd0);
    chk("stall_ctrl", 64'(ex_ctrl), 64'd0);
    chk("stall_cnt", 64'(stall_count), 64'd1);
    stall = 0;
    tick();
    chk("release_valid", 64'(ex_valid), 64'd1);
    chk("release_ctrl", 64'(ex_ctrl), 64'h00F3);

    // Freeze beats stall and flush
    en = 0; stall = 1; flush = 1; id_ctrl = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_ctrl", 64'(ex_ctrl), 64'h00F3);
      chk("frz_cnt", 64'(stall_count), 64'd1);
    end
    en = 1; flush = 0;
    tick();
    chk("unfrz_valid", 64'(ex_valid), 64'd0);
    chk("unfrz_cnt", 64'(stall_count), 64'd2);

    // Flush+stall then flush alone: one increment only
    stall = 0; tick();
    stall = 1; flush = 1; tick();
    chk("fs_valid", 64'(ex_valid), 64'd0);
    stall = 0; tick();
    chk("f_valid", 64'(ex_valid), 64'd0);
    chk("fs_cnt", 64'(stall_count), 64'd3);
    flush = 0;
    chk_model("dir");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      nRST = ($urandom_range(0, 29) != 0);
      en = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = 1'($urandom); id_ctrl = 16'($urandom);
      id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm = $urandom; id_wsel = 5'($urandom);
      tick();
      forwarda_src = 2'($urandom); forwardb_src = 2'($urandom); memadd_forward = 2'($urandom);
      exmem_alu = $urandom; intomem = $urandom;
      #1 chk_model("rnd");
    end

    // Saturation, then reset mid-count
    nRST = 0; en = 1; flush = 0; stall = 0; tick();
    nRST = 1; stall = 1;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_cnt", 64'(stall_count), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(stall_count), 64'hFFFF);
    nRST = 0; tick();
    chk("sat_rst_cnt", 64'(stall_count), 64'd0);
    chk("sat_rst_valid", 64'(ex_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idex_forward_stage.md
Name: idex_forward_stage

Overview:
- Consumer end of the hazard unit's forwarding/stall outputs.
- Owns the ID/EX pipeline register and the EX-stage operand and store-data forwarding muxes.
- Turns `stall` into bubble insertion and keeps a saturating stall-cycle counter for debug.
- Sits between the decode/register-file stage and the ALU/EX-MEM latch.

Parameters:
- WORD_W, 32, datapath word width
- CTRL_W, 16, width of packed decoded control bundle
- REG_W, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- en  in  1  global pipeline enable (low = memory wait, freeze all state)
- flush  in  1  branch/jump squash of the instruction entering EX
- stall  in  1  hazard unit stall request
- forwarda_src  in  2  operand A select: 00 none, 01 EX/MEM ALU result, 10 IntoMem (writeback) data, 11 reserved
- forwardb_src  in  2  operand B select, same encoding
- memadd_forward  in  2  store-data select, same encoding
- id_valid  in  1  decode stage holds a real instruction
- id_ctrl  in  CTRL_W  decoded control bundle
- id_rdat1  in  WORD_W  register file read port 1
- id_rdat2  in  WORD_W  register file read port 2
- id_imm  in  WORD_W  extended immediate
- id_wsel  in  REG_W  destination register
- exmem_alu  in  WORD_W  ALU result currently in EX/MEM
- intomem  in  WORD_W  value being written back to the register file
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_porta  out  WORD_W  forwarded operand A
- ex_portb  out  WORD_W  forwarded operand B (register path, before any immediate mux)
- ex_store_data  out  WORD_W  forwarded store data
- ex_imm  out  WORD_W  registered immediate
- ex_wsel  out  REG_W  registered destination
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (nRST=0 at edge): all ID/EX registers cleared, ex_valid=0, ex_ctrl=0, stall_count=0.
  - ex_porta, ex_portb and ex_store_data then read 0 unless forwarding selects a nonzero source.
- Reset takes priority over en, flush and stall.
- Register update priority at each edge, with nRST=1:
  1. en=0: hold every register, including stall_count.
  2. else flush=1 or stall=1: load a bubble (ex_valid=0, ex_ctrl=0, ex_wsel=0, data registers 0).
  3. else: capture the id_* inputs; ex_valid=id_valid.
- Latency: id_* inputs appear on ex_* one cycle after the capturing edge.
- Bubble semantics: stall=1 inserts a bubble into EX. Upstream (PC, IF/ID) holds the instruction; this block does not re-capture it.
- flush and stall together produce a single bubble; they are not additive.
- Forwarding muxes are combinational from the registered rdat1/rdat2 and the live exmem_alu/intomem:
  - ex_porta: 00 → rdat1_q, 01 → exmem_alu, 10 → intomem, 11 → rdat1_q.
  - ex_portb: same encoding on rdat2_q, using forwardb_src.
  - ex_store_data: same encoding on rdat2_q, using memadd_forward, independent of forwardb_src.
- Forward selects are not registered; they are evaluated in the same cycle as the EX instruction.
- Muxes operate even when ex_valid=0; downstream gates on ex_valid.
- stall_count:
  - Increments on each edge with nRST=1, en=1, stall=1.
  - Saturates at all-ones.
  - Flush does not count.
  - Reset mid-count clears it to 0.
- Bubble during reset-release: first edge with nRST=1 follows the normal priority rules.
- No internal timeouts; stall may be held indefinitely.

Test Plan:
- Reset/capture: nRST=0 two cycles, then id_valid=1, id_rdat1=0x11, id_rdat2=0x22, id_wsel=5, all forward selects 00.
  - One edge later: ex_valid=1, ex_porta=0x11, ex_portb=0x22, ex_wsel=5, stall_count=0.
- Forwarding: registered rdat1=0x11, exmem_alu=0xAAAA, intomem=0xBBBB.
  - forwarda_src=01 → ex_porta=0xAAAA; forwarda_src=10 → 0xBBBB; forwarda_src=11 → 0x11.
  - With memadd_forward=10 and forwardb_src=00: ex_store_data=0xBBBB, ex_portb=rdat2_q.
- Load-use stall: stall=1 for one cycle with id_valid=1, id_ctrl=0x00F3.
  - Next edge: ex_valid=0, ex_ctrl=0, stall_count=1.
  - Stall released, same inputs held: following edge ex_valid=1, ex_ctrl=0x00F3.
- Freeze priority: en=0 with stall=1 and flush=1 for 3 cycles.
  - ex_* unchanged from prior value; stall_count unchanged.
  - en=1 with stall=1: bubble loaded and count +1.
- Flush+stall simultaneous, then flush alone: one bubble per edge; stall_count increments only on the stall edge (+1 total).
- Saturation/reset: force 65535 stall cycles → stall_count=0xFFFF, stays 0xFFFF after one more stall.
  - Then nRST=0 for one edge with stall=1: stall_count=0, ex_valid=0.
